// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 layer compositor: ILI9341 command bytes,
// the default colour key, the frame FSM states and the window-setup sequence.
package lt24_pkg;

    localparam logic [7:0]  CMD_COLADDR  = 8'h2A;
    localparam logic [7:0]  CMD_PAGEADDR = 8'h2B;
    localparam logic [7:0]  CMD_MEMWR    = 8'h2C;

    localparam logic [15:0] LT24_TRANSPARENT_DEFAULT = 16'hF81F;

    localparam int unsigned CMD_WORDS = 11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StBgRd,
        StSprScan,
        StPixWr,
        StDone
    } lt24_state_e;

    // Window-setup word idx as {rs, data}; col_last/row_last are H_RES-1 / V_RES-1.
    function automatic logic [16:0] f_cmd_word(input logic [3:0]  idx,
                                               input logic [15:0] col_last,
                                               input logic [15:0] row_last);
        logic [16:0] w;
        case (idx)
            4'd0:       w = {1'b0, 8'h00, CMD_COLADDR};
            4'd1, 4'd2: w = {1'b1, 16'h0000};
            4'd3:       w = {1'b1, 8'h00, col_last[15:8]};
            4'd4:       w = {1'b1, 8'h00, col_last[7:0]};
            4'd5:       w = {1'b0, 8'h00, CMD_PAGEADDR};
            4'd6, 4'd7: w = {1'b1, 16'h0000};
            4'd8:       w = {1'b1, 8'h00, row_last[15:8]};
            4'd9:       w = {1'b1, 8'h00, row_last[7:0]};
            default:    w = {1'b0, 8'h00, CMD_MEMWR};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_layer_compositor_bus_writer.sv
// 8080-style write strobe engine: one word per WR_LOW low + WR_HIGH high cycles.
// Data and rs are launched with the falling strobe and held until the next word.
module lt24_bus_writer #(
    parameter int unsigned WR_LOW  = 2,
    parameter int unsigned WR_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_word,
    input  logic        i_rs,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_wr_n,
    output logic [15:0] o_d,
    output logic        o_rs
);

    localparam int unsigned CNT_W = $clog2(WR_LOW + WR_HIGH + 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wr_n;
    logic [15:0]      r_d;
    logic             r_rs;
    logic             w_last;

    assign w_last  = r_active && (r_cnt == CNT_W'(WR_LOW + WR_HIGH - 1));
    // Accepting in the final high cycle keeps the high phase at exactly WR_HIGH.
    assign o_ready = !r_active || w_last;

    // Strobe sequencing and word launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_wr_n   <= 1'b1;
            r_d      <= 16'h0000;
            r_rs     <= 1'b1;
        end else if (i_valid && o_ready) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_wr_n   <= 1'b0;
            r_d      <= i_word;
            r_rs     <= i_rs;
        end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WR_LOW - 1)) begin
                r_wr_n <= 1'b1;
            end
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_wr_n = r_wr_n;
    assign o_d    = r_d;
    assign o_rs   = r_rs;

endmodule

// File: rtl/lt24_layer_compositor.sv
// LT24 layer compositor: scaled background plus NUM_SPRITES colour-keyed sprites,
// streamed as an RGB565 frame to the ILI9341 8080 port.
// Optional build macro LT24_SPRITE_FLIP_EN adds per-sprite horizontal mirroring.
module lt24_layer_compositor
    import lt24_pkg::*;
#(
    parameter int unsigned H_RES       = 240,
    parameter int unsigned V_RES       = 320,
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned BG_SCALE    = 4,
    parameter int unsigned BG_ADDR_W   = 13,
    parameter int unsigned SPR_ADDR_W  = 12,
    parameter logic [15:0] TRANSPARENT = LT24_TRANSPARENT_DEFAULT,
    parameter int unsigned WR_LOW      = 2,
    parameter int unsigned WR_HIGH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_SPRITES*9-1:0] sprite_x,
    input  logic [NUM_SPRITES*9-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
`ifdef LT24_SPRITE_FLIP_EN
    input  logic [NUM_SPRITES-1:0]   sprite_flip,
`endif
    output logic [BG_ADDR_W-1:0]     bg_address,
    output logic                     bg_chipselect,
    output logic                     bg_clken,
    input  logic [15:0]              bg_readdata,
    output logic [SPR_ADDR_W-1:0]    spr_address,
    output logic                     spr_chipselect,
    output logic                     spr_clken,
    input  logic [15:0]              spr_readdata,
    output logic                     lcd_cs_n,
    output logic                     lcd_rs,
    output logic                     lcd_rd_n,
    output logic                     lcd_wr_n,
    output logic [15:0]              lcd_d,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int unsigned SPR_XW = $clog2(SPR_W);
    localparam int unsigned BG_SH  = $clog2(BG_SCALE);

    lt24_state_e          r_state, w_state_d;
    logic                 r_phase;
    logic [IDX_W-1:0]     r_spr_idx;
    logic [3:0]           r_cmd_idx;
    logic [9:0]           r_x, r_y;
    logic [15:0]          r_colour;
    logic [8:0]           r_sx [NUM_SPRITES];
    logic [8:0]           r_sy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_en;
`ifdef LT24_SPRITE_FLIP_EN
    logic [NUM_SPRITES-1:0] r_flip;
`endif
    logic                 r_busy, r_frame_done, r_cs_n;

    logic                 w_wr_valid, w_wr_rs, w_wr_ready;
    logic [15:0]          w_wr_word;
    logic                 w_bg_rd, w_spr_rd;
    logic [16:0]          w_cmd;
    logic                 w_last_x, w_last_y, w_last_spr, w_hit, w_opaque;
    logic [9:0]           w_sx10, w_sy10, w_dy;
    logic [SPR_XW-1:0]    w_dx, w_dx_sel;
    logic [BG_ADDR_W-1:0] w_bg_addr;
    logic [SPR_ADDR_W-1:0] w_spr_addr;

    assign w_cmd      = f_cmd_word(r_cmd_idx, 16'(H_RES - 1), 16'(V_RES - 1));
    assign w_last_x   = (r_x == 10'(H_RES - 1));
    assign w_last_y   = (r_y == 10'(V_RES - 1));
    assign w_last_spr = (r_spr_idx == IDX_W'(NUM_SPRITES - 1));
    assign w_opaque   = (spr_readdata != TRANSPARENT);

    // Hit test and address for the sprite currently under scan (10-bit arithmetic).
    assign w_sx10 = {1'b0, r_sx[r_spr_idx]};
    assign w_sy10 = {1'b0, r_sy[r_spr_idx]};
    assign w_hit  = r_en[r_spr_idx]
                    && (r_x >= w_sx10) && (r_x < w_sx10 + 10'(SPR_W))
                    && (r_y >= w_sy10) && (r_y < w_sy10 + 10'(SPR_H));
    assign w_dx   = SPR_XW'(r_x) - SPR_XW'(w_sx10);
    assign w_dy   = r_y - w_sy10;
`ifdef LT24_SPRITE_FLIP_EN
    // SPR_W is a power of two, so SPR_W-1-dx is the bitwise complement of dx.
    assign w_dx_sel = r_flip[r_spr_idx] ? ~w_dx : w_dx;
`else
    assign w_dx_sel = w_dx;
`endif
    assign w_spr_addr = SPR_ADDR_W'(r_spr_idx) * SPR_ADDR_W'(SPR_W * SPR_H)
                        + SPR_ADDR_W'(w_dy) * SPR_ADDR_W'(SPR_W)
                        + SPR_ADDR_W'(w_dx_sel);
    assign w_bg_addr  = BG_ADDR_W'(r_y >> BG_SH) * BG_ADDR_W'(H_RES / BG_SCALE)
                        + BG_ADDR_W'(r_x >> BG_SH);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode plus writer and RAM read strobes.
    always_comb begin
        w_state_d  = r_state;
        w_wr_valid = 1'b0;
        w_wr_word  = 16'h0000;
        w_wr_rs    = 1'b1;
        w_bg_rd    = 1'b0;
        w_spr_rd   = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StCmd;
                end
            end
            StCmd: begin
                w_wr_valid = 1'b1;
                w_wr_word  = w_cmd[15:0];
                w_wr_rs    = w_cmd[16];
                if (w_wr_ready && (r_cmd_idx == 4'(CMD_WORDS - 1))) begin
                    w_state_d = StBgRd;
                end
            end
            StBgRd: begin
                if (!r_phase) begin
                    w_bg_rd = 1'b1;
                end else begin
                    w_state_d = StSprScan;
                end
            end
            StSprScan: begin
                if (!r_phase) begin
                    if (w_hit) begin
                        w_spr_rd = 1'b1;
                    end else if (w_last_spr) begin
                        w_state_d = StPixWr;
                    end
                end else if (w_opaque || w_last_spr) begin
                    w_state_d = StPixWr;
                end
            end
            StPixWr: begin
                w_wr_valid = 1'b1;
                w_wr_word  = r_colour;
                if (w_wr_ready) begin
                    w_state_d = (w_last_x && w_last_y) ? StDone : StBgRd;
                end
            end
            StDone: begin
                // Ready here means the last pixel's high phase is in its final cycle.
                if (w_wr_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath: sprite latch, counters, pixel colour and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= 1'b0;
            r_spr_idx    <= '0;
            r_cmd_idx    <= 4'd0;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_colour     <= 16'h0000;
            r_en         <= '0;
`ifdef LT24_SPRITE_FLIP_EN
            r_flip       <= '0;
`endif
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cs_n       <= 1'b1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sx[i] <= 9'd0;
                r_sy[i] <= 9'd0;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < NUM_SPRITES; i++) begin
                            r_sx[i] <= sprite_x[9*i +: 9];
                            r_sy[i] <= sprite_y[9*i +: 9];
                        end
                        r_en      <= sprite_en;
`ifdef LT24_SPRITE_FLIP_EN
                        r_flip    <= sprite_flip;
`endif
                        r_busy    <= 1'b1;
                        r_cmd_idx <= 4'd0;
                        r_x       <= 10'd0;
                        r_y       <= 10'd0;
                        r_phase   <= 1'b0;
                    end
                end
                StCmd: begin
                    if (w_wr_ready) begin
                        r_cmd_idx <= r_cmd_idx + 4'd1;
                        r_cs_n    <= 1'b0;
                    end
                end
                StBgRd: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_colour  <= bg_readdata;
                        r_phase   <= 1'b0;
                        r_spr_idx <= '0;
                    end
                end
                StSprScan: begin
                    if (!r_phase) begin
                        if (w_hit) begin
                            r_phase <= 1'b1;
                        end else if (!w_last_spr) begin
                            r_spr_idx <= r_spr_idx + 1'b1;
                        end
                    end else begin
                        r_phase <= 1'b0;
                        if (w_opaque) begin
                            r_colour <= spr_readdata;
                        end else if (!w_last_spr) begin
                            r_spr_idx <= r_spr_idx + 1'b1;
                        end
                    end
                end
                StPixWr: begin
                    if (w_wr_ready) begin
                        if (w_last_x) begin
                            r_x <= 10'd0;
                            r_y <= w_last_y ? 10'd0 : r_y + 10'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                StDone: begin
                    if (w_wr_ready) begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_cs_n       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    lt24_bus_writer #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_writer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_word  (w_wr_word),
        .i_rs    (w_wr_rs),
        .i_valid (w_wr_valid),
        .o_ready (w_wr_ready),
        .o_wr_n  (lcd_wr_n),
        .o_d     (lcd_d),
        .o_rs    (lcd_rs)
    );

    assign bg_chipselect  = w_bg_rd;
    assign bg_clken       = w_bg_rd;
    assign bg_address     = w_bg_rd ? w_bg_addr : '0;
    assign spr_chipselect = w_spr_rd;
    assign spr_clken      = w_spr_rd;
    assign spr_address    = w_spr_rd ? w_spr_addr : '0;

    assign lcd_cs_n   = r_cs_n;
    assign lcd_rd_n   = 1'b1;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
